// File: rtl/calc1_port_scheduler.sv
// Shares one calc1 ALU among NPORTS requesters: captures two-cycle requests,
// arbitrates round-robin, issues over valid/done and routes the response back.
module calc1_port_scheduler #(
    parameter int unsigned NPORTS  = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   c_clk,
    input  logic                   reset_n,
    input  logic [CW*NPORTS-1:0]   req_cmd_in,
    input  logic [DW*NPORTS-1:0]   req_data_in,
    output logic [2*NPORTS-1:0]    out_resp,
    output logic [DW*NPORTS-1:0]   out_data,
    output logic [NPORTS-1:0]      port_busy,
    output logic                   alu_valid,
    output logic [CW-1:0]          alu_cmd,
    output logic [DW-1:0]          alu_op1,
    output logic [DW-1:0]          alu_op2,
    input  logic                   alu_done,
    input  logic [1:0]             alu_resp,
    input  logic [DW-1:0]          alu_data
);

    localparam int unsigned IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                       state_q, state_d;
    logic [IW-1:0]                ptr_q, ptr_d, gnt_q, gnt_d;
    logic [TW-1:0]                cnt_q, cnt_d;
    logic [NPORTS-1:0][CW-1:0]    cmd_q, cmd_d;
    logic [NPORTS-1:0][DW-1:0]    op1_q, op1_d, op2_q, op2_d;
    logic [NPORTS-1:0]            cap_q, cap_d, pend_q, pend_d;
    logic                         alu_valid_q, alu_valid_d;
    logic [CW-1:0]                alu_cmd_q, alu_cmd_d;
    logic [DW-1:0]                alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
    logic [NPORTS-1:0][1:0]       resp_q, resp_d;
    logic [NPORTS-1:0][DW-1:0]    rdata_q, rdata_d;

    logic                         arb_found;
    logic [IW-1:0]                arb_sel, arb_idx;
    logic [CW-1:0]                sel_cmd;
    logic                         cmd_ok;

    // Round-robin search: first pending port at or after the pointer, with wrap
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            arb_idx = IW'((32'(ptr_q) + k) % NPORTS);
            if (!arb_found && pend_q[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
        sel_cmd = cmd_q[arb_sel];
        cmd_ok  = (sel_cmd == CW'(1)) || (sel_cmd == CW'(2)) ||
                  (sel_cmd == CW'(5)) || (sel_cmd == CW'(6));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        cap_d       = cap_q;
        pend_d      = pend_q;
        alu_valid_d = 1'b0;
        alu_cmd_d   = alu_cmd_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        resp_d      = '0;
        rdata_d     = '0;

        // Per-port capture; a command arriving in the port's own response cycle is dropped
        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (cap_q[i]) begin
                op2_d[i]  = req_data_in[i*DW +: DW];
                cap_d[i]  = 1'b0;
                pend_d[i] = 1'b1;
            end else if (!pend_q[i] && (req_cmd_in[i*CW +: CW] != '0) &&
                         !((state_q == S_RESP) && (gnt_q == IW'(i)))) begin
                cmd_d[i] = req_cmd_in[i*CW +: CW];
                op1_d[i] = req_data_in[i*DW +: DW];
                cap_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d = arb_sel;
                    ptr_d = IW'((32'(arb_sel) + 32'd1) % NPORTS);
                    if (cmd_ok) begin
                        state_d     = S_ISSUE;
                        alu_valid_d = 1'b1;
                        alu_cmd_d   = sel_cmd;
                        alu_op1_d   = op1_q[arb_sel];
                        alu_op2_d   = op2_q[arb_sel];
                    end else begin
                        state_d         = S_RESP;
                        resp_d[arb_sel] = 2'd3;
                        pend_d[arb_sel] = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (alu_done) begin
                    state_d        = S_RESP;
                    resp_d[gnt_q]  = alu_resp;
                    rdata_d[gnt_q] = alu_data;
                    pend_d[gnt_q]  = 1'b0;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d       = S_RESP;
                    resp_d[gnt_q] = 2'd3;
                    pend_d[gnt_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            cmd_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            cap_q       <= '0;
            pend_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_cmd_q   <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            resp_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            cap_q       <= cap_d;
            pend_q      <= pend_d;
            alu_valid_q <= alu_valid_d;
            alu_cmd_q   <= alu_cmd_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
        end
    end

    assign out_resp  = resp_q;
    assign out_data  = rdata_q;
    assign port_busy = pend_q;
    assign alu_valid = alu_valid_q;
    assign alu_cmd   = alu_cmd_q;
    assign alu_op1   = alu_op1_q;
    assign alu_op2   = alu_op2_q;

endmodule

// File: tb/tb_calc1_port_scheduler.sv
// Scoreboard bench for calc1_port_scheduler with a behavioural calc1 ALU model.
module tb_calc1_port_scheduler;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 16;

    logic                c_clk;
    logic                reset_n;
    logic [CW*NP-1:0]    req_cmd_in;
    logic [DW*NP-1:0]    req_data_in;
    logic [2*NP-1:0]     out_resp;
    logic [DW*NP-1:0]    out_data;
    logic [NP-1:0]       port_busy;
    logic                alu_valid;
    logic [CW-1:0]       alu_cmd;
    logic [DW-1:0]       alu_op1, alu_op2;
    logic                alu_done;
    logic [1:0]          alu_resp;
    logic [DW-1:0]       alu_data;

    calc1_port_scheduler #(.NPORTS(NP), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
        .c_clk(c_clk), .reset_n(reset_n),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data), .port_busy(port_busy),
        .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_done(alu_done), .alu_resp(alu_resp), .alu_data(alu_data)
    );

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] issue_log[$];
    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          alu_lat = 1;
    bit          hang_once = 0;

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    initial forever begin
        @(posedge c_clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [CW-1:0] c, input logic [DW-1:0] d);
        req_cmd_in[p*CW +: CW]  = c;
        req_data_in[p*DW +: DW] = d;
    endtask

    function automatic logic [33:0] alu_calc(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [32:0] s;
        case (c)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                return {(s[32] ? 2'd2 : 2'd1), s[31:0]};
            end
            4'd2: return {((a < b) ? 2'd2 : 2'd1), a - b};
            4'd5: return {2'd1, a << b[4:0]};
            4'd6: return {2'd1, a >> b[4:0]};
            default: return {2'd3, 32'd0};
        endcase
    endfunction

    function automatic void push_exp(input int p, input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b, input bit hang);
        exp_t        e;
        logic [33:0] r;
        r      = alu_calc(c, a, b);
        e.port = p;
        if (hang || !(c == 4'd1 || c == 4'd2 || c == 4'd5 || c == 4'd6)) begin
            e.resp = 2'd3;
            e.data = 32'd0;
        end else begin
            e.resp = r[33:32];
            e.data = r[31:0];
        end
        sb.push_back(e);
    endfunction

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || port_busy != '0) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) chk("drain_timeout", 64'(sb.size()), 0);
    endtask

    task automatic chk_log(input string tag, input logic [31:0] exp);
        if (issue_log.size() == 0) chk({tag, "_missing"}, 64'(issue_log.size()), 1);
        else chk(tag, issue_log.pop_front(), exp);
    endtask

    // Behavioural ALU: logs each issue, answers after alu_lat cycles unless told to hang
    initial begin
        logic [33:0] r;
        alu_done = 1'b0;
        alu_resp = 2'd0;
        alu_data = '0;
        forever begin
            @(negedge c_clk);
            if (reset_n && alu_valid) begin
                issue_log.push_back(alu_op1);
                r = alu_calc(alu_cmd, alu_op1, alu_op2);
                if (hang_once) begin
                    hang_once = 0;
                end else begin
                    repeat (alu_lat - 1) @(posedge c_clk);
                    @(posedge c_clk);
                    #1;
                    alu_done = 1'b1;
                    alu_resp = r[33:32];
                    alu_data = r[31:0];
                    @(posedge c_clk);
                    #1;
                    alu_done = 1'b0;
                    alu_resp = 2'd0;
                    alu_data = '0;
                end
            end
        end
    end

    // Response monitor: every nonzero slice must match the oldest expectation for that port
    initial begin
        int nr;
        int fi;
        forever begin
            @(negedge c_clk);
            if (reset_n) begin
                nr = 0;
                for (int p = 0; p < NP; p++) begin
                    if (out_resp[2*p +: 2] != 2'd0) begin
                        nr++;
                        fi = -1;
                        for (int k = 0; k < sb.size(); k++)
                            if (fi < 0 && sb[k].port == p) fi = k;
                        if (fi < 0) begin
                            chk($sformatf("unexp_resp_p%0d", p), out_resp[2*p +: 2], 0);
                        end else begin
                            chk($sformatf("resp_p%0d", p), out_resp[2*p +: 2], sb[fi].resp);
                            chk($sformatf("data_p%0d", p), out_data[DW*p +: DW], sb[fi].data);
                            sb.delete(fi);
                        end
                    end
                end
                if (nr > 1) chk("multi_resp", 64'(nr), 1);
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        int iss;
        reset_n     = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        repeat (3) tick();
        chk("rst_out_resp", out_resp, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", port_busy, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_alu_cmd", alu_cmd, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_op2", alu_op2, 0);
        reset_n = 1'b1;
        tick();

        // Minimum latency: cmd at cycle 0, response in cycle 5
        set_port(0, 4'd1, 32'd5); push_exp(0, 4'd1, 32'd5, 32'd7, 0);
        chk("t1_busy_c0", port_busy[0], 0);
        tick();
        set_port(0, 4'd0, 32'd7);
        chk("t1_busy_c1", port_busy[0], 0);
        tick();
        set_port(0, 4'd0, 32'd0);
        chk("t1_busy_c2", port_busy[0], 1);
        chk("t1_valid_c2", alu_valid, 0);
        tick();
        chk("t1_valid_c3", alu_valid, 1);
        chk("t1_alu_cmd", alu_cmd, 1);
        chk("t1_alu_op1", alu_op1, 5);
        chk("t1_alu_op2", alu_op2, 7);
        tick();
        chk("t1_resp_c4", out_resp, 0);
        chk("t1_valid_c4", alu_valid, 0);
        tick();
        chk("t1_resp_c5", out_resp, 8'h01);
        chk("t1_data_c5", out_data[31:0], 12);
        chk("t1_data_others", out_data[127:32], 0);
        chk("t1_busy_c5", port_busy[0], 0);
        tick();
        chk("t1_resp_c6", out_resp, 0);
        wait_drain(50);

        // All four ports in the same cycle from pointer 0, then ports 1 and 3
        do_reset();
        issue_log.delete();
        for (int p = 0; p < NP; p++) begin
            set_port(p, 4'd1, (p == 3) ? 32'hFFFF_FFFF : 32'(100 + p));
            push_exp(p, 4'd1, (p == 3) ? 32'hFFFF_FFFF : 32'(100 + p), (p == 3) ? 32'd2 : 32'd1, 0);
        end
        tick();
        for (int p = 0; p < NP; p++) set_port(p, 4'd0, (p == 3) ? 32'd2 : 32'd1);
        tick();
        req_data_in = '0;
        chk("t2_busy_all", port_busy, 4'hF);
        wait_drain(200);
        chk_log("t2_order0", 32'd100);
        chk_log("t2_order1", 32'd101);
        chk_log("t2_order2", 32'd102);
        chk_log("t2_order3", 32'hFFFF_FFFF);

        set_port(3, 4'd6, 32'd256); push_exp(3, 4'd6, 32'd256, 32'd4, 0);
        set_port(1, 4'd5, 32'd3);   push_exp(1, 4'd5, 32'd3, 32'd4, 0);
        tick();
        set_port(3, 4'd0, 32'd4);
        set_port(1, 4'd0, 32'd4);
        tick();
        req_data_in = '0;
        wait_drain(200);
        chk_log("t2b_order0", 32'd3);
        chk_log("t2b_order1", 32'd256);

        // Invalid command answered locally in cycle 3, ALU untouched
        set_port(2, 4'd4, 32'd1); push_exp(2, 4'd4, 32'd1, 32'd1, 0);
        tick();
        set_port(2, 4'd0, 32'd1);
        tick();
        set_port(2, 4'd0, 32'd0);
        chk("t3_valid_c2", alu_valid, 0);
        chk("t3_busy_c2", port_busy[2], 1);
        tick();
        chk("t3_resp_c3", out_resp, 8'h30);
        chk("t3_data_c3", out_data, 0);
        chk("t3_valid_c3", alu_valid, 0);
        chk("t3_busy_c3", port_busy[2], 0);
        chk("t3_alu_cmd_hold", alu_cmd, 6);
        chk("t3_alu_op1_hold", alu_op1, 256);
        wait_drain(50);
        chk("t3_no_issue", 64'(issue_log.size()), 0);

        // Hung ALU: port0 times out after TO wait cycles, port1 then served normally
        hang_once = 1;
        set_port(0, 4'd1, 32'd10); push_exp(0, 4'd1, 32'd10, 32'd1, 1);
        set_port(1, 4'd1, 32'd20); push_exp(1, 4'd1, 32'd20, 32'd2, 0);
        tick();
        set_port(0, 4'd0, 32'd1);
        set_port(1, 4'd0, 32'd2);
        tick();
        req_data_in = '0;
        n = 0;
        while (!alu_valid && n < 50) begin tick(); n++; end
        if (n >= 50) chk("t4_issue_timeout", 64'(n), 0);
        iss = cyc;
        n = 0;
        while (out_resp[1:0] == 2'd0 && n < 60) begin tick(); n++; end
        chk("t4_timeout_lat", 64'(cyc - iss), TO + 1);
        chk("t4_timeout_resp", out_resp, 8'h03);
        wait_drain(100);
        chk_log("t4_order0", 32'd10);
        chk_log("t4_order1", 32'd20);

        // Busy port: extra commands dropped, including one in its own response cycle
        alu_lat = 4;
        set_port(1, 4'd1, 32'd1); push_exp(1, 4'd1, 32'd1, 32'd1, 0);
        tick();
        set_port(1, 4'd2, 32'd1);
        tick();
        set_port(1, 4'd0, 32'd0);
        chk("t5_busy_c2", port_busy[1], 1);
        tick();
        set_port(1, 4'd2, 32'd99);
        chk("t5_busy_c3", port_busy[1], 1);
        tick();
        set_port(1, 4'd0, 32'd77);
        chk("t5_busy_c4", port_busy[1], 1);
        tick();
        set_port(1, 4'd0, 32'd0);
        chk("t5_busy_c5", port_busy[1], 1);
        n = 0;
        while (out_resp[3:2] == 2'd0 && n < 40) begin tick(); n++; end
        chk("t5_resp_seen", out_resp, 8'h04);
        chk("t5_busy_resp", port_busy[1], 0);
        set_port(1, 4'd1, 32'd55);
        tick();
        set_port(1, 4'd0, 32'd66);
        tick();
        set_port(1, 4'd0, 32'd0);
        chk("t5_resp_drop_c2", port_busy[1], 0);
        repeat (5) tick();
        chk("t5_resp_drop_c7", port_busy[1], 0);
        wait_drain(50);
        alu_lat = 1;

        // Reset while waiting on a hung ALU with two ports pending
        hang_once = 1;
        issue_log.delete();
        set_port(0, 4'd1, 32'd1);
        set_port(2, 4'd1, 32'd2);
        tick();
        set_port(0, 4'd0, 32'd1);
        set_port(2, 4'd0, 32'd2);
        tick();
        req_data_in = '0;
        repeat (4) tick();
        chk("t6_busy_pre", port_busy, 4'b0101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_resp", out_resp, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_busy", port_busy, 0);
        chk("t6_rst_valid", alu_valid, 0);
        chk("t6_rst_cmd", alu_cmd, 0);
        chk("t6_rst_op1", alu_op1, 0);
        hang_once = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("t6_quiet_busy", port_busy, 0);
        issue_log.delete();
        set_port(3, 4'd1, 32'd9); push_exp(3, 4'd1, 32'd9, 32'd1, 0);
        set_port(1, 4'd1, 32'd7); push_exp(1, 4'd1, 32'd7, 32'd1, 0);
        tick();
        set_port(3, 4'd0, 32'd1);
        set_port(1, 4'd0, 32'd1);
        tick();
        req_data_in = '0;
        wait_drain(100);
        chk_log("t6_order0", 32'd7);
        chk_log("t6_order1", 32'd9);

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/calc1_port_scheduler.md
Name: calc1_port_scheduler

Overview:
- Front-end controller that shares one calc1 add/shift ALU among NPORTS requester ports.
- Captures the calc1 two-cycle request protocol on every port: a command plus operand1, then operand2.
- Arbitrates pending requests round-robin, issues them to the ALU with a valid/done handshake, and routes the response back to the originating port.
- Rejects invalid commands locally and times out a hung ALU.

Parameters:
- NPORTS, 4, number of requester ports
- DW, 32, operand/result width
- CW, 4, command width
- TIMEOUT, 16, max cycles in WAIT before a forced error response

Ports:
- c_clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_cmd_in  in  CW*NPORTS  per-port command, slice i = port i; 0 = no-op
- req_data_in  in  DW*NPORTS  per-port operand bus
- out_resp  out  2*NPORTS  per-port response: 0 none, 1 success, 2 overflow/underflow, 3 invalid/error
- out_data  out  DW*NPORTS  per-port result, valid only when out_resp slice != 0
- port_busy  out  NPORTS  port holds a pending or in-flight request
- alu_valid  out  1  one-cycle issue strobe to ALU
- alu_cmd  out  CW  command to ALU
- alu_op1  out  DW  operand1 to ALU
- alu_op2  out  DW  operand2 to ALU
- alu_done  in  1  ALU result strobe
- alu_resp  in  2  ALU response code, sampled with alu_done
- alu_data  in  DW  ALU result, sampled with alu_done

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs 0, all pending/busy flags cleared, FSM=IDLE, RR pointer=0. Reset mid-operation discards every captured and in-flight request; no response is ever produced for them.
- Port capture:
  - A port with port_busy=0 that sees nonzero cmd in cycle T latches cmd and data as op1.
  - In cycle T+1 it latches data as op2; cmd in T+1 is ignored.
  - pending=1 and port_busy=1 from cycle T+2.
  - Nonzero cmd while port_busy=1 is dropped silently, with no response.
  - port_busy clears in the port's RESP cycle. A cmd in that same cycle is dropped; a new cmd is accepted from the next cycle.
- Arbiter (evaluated in IDLE only):
  - Grant goes to the first pending port at or after the RR pointer, in ascending index with wrap.
  - After a grant, pointer = (granted+1) mod NPORTS.
  - A port whose op2 is still being captured is not eligible.
- FSM:
  - IDLE: no pending ports -> stay. Granted cmd in {1,2,5,6} -> ISSUE. Otherwise -> RESP with resp=3, data=0 (ALU untouched).
  - ISSUE (1 cycle): alu_valid=1; alu_cmd/op1/op2 = granted port's latched values -> WAIT. alu_cmd/op1/op2 hold their values until the next ISSUE.
  - WAIT: alu_done=1 -> latch alu_resp/alu_data -> RESP. The cycle counter reaching TIMEOUT without alu_done -> RESP with resp=3, data=0. alu_done outside WAIT is ignored.
  - RESP (1 cycle): granted port's out_resp/out_data slice = latched result; all other slices 0; clear that port's pending/busy -> IDLE.
- Minimum latency (1-cycle ALU): cmd at cycle 0, grant in IDLE at cycle 2, alu_valid at cycle 3, alu_done at cycle 4, out_resp at cycle 5.
- out_resp slices are 0 in every non-RESP cycle; at most one port responds per cycle.
- The scheduler never alters data; overflow detection belongs to the ALU.

Test Plan:
- Port0 cmd=1 op1=5 op2=7; ALU done after 1 cycle with resp=1 data=12 -> port0 out_resp=1, out_data=12 exactly at cycle 5, all other ports 0, port_busy[0] drops that cycle.
- Ports 0–3 issue cmd=1 in the same cycle, pointer=0 -> ALU sees ports in order 0,1,2,3. Next round with port1 and port3 pending and pointer=0 -> order 1,3.
- Port2 cmd=4 op1=1 op2=1 -> alu_valid never asserts; port2 out_resp=3, out_data=0 at cycle 3.
- ALU never asserts alu_done, TIMEOUT=16 -> out_resp=3 after 16 WAIT cycles; next pending port is then served normally.
- Port1 busy, drives second cmd=2 -> single response only for the first request; port_busy[1]=1 throughout.
- Pull reset_n low while in WAIT with 2 ports pending -> outputs 0 immediately. After release, no stale out_resp appears; new cmd on port3 is served with pointer=0 semantics.
